// File: rtl/hdmi_cfg_sequencer.sv
// hdmi_cfg_sequencer: pulses the ADV7611 reset, then walks a config ROM
// issuing single-byte I2C writes with optional read-back verify/retry.
//
// Ports:
//   CLOCK_50, RESET_N      : 50 MHz clock, async active-low reset
//   start                  : one-cycle pulse, begins a run when not busy
//   tbl_addr / tbl_data    : config ROM index / entry (1-clock latency)
//                            entry = {dev[6:0], verify, subaddr, data}
//   i2c_req .. i2c_busy    : request/busy handshake to the I2C master
//   rx_reset_n             : ADV7611 reset, active low
//   busy, done, error      : run status (done/error sticky)
//   err_index, entry_count : failing entry index, completed entries
module hdmi_cfg_sequencer #(
    parameter int ADDR_W           = 12,
    parameter int TABLE_DEPTH      = 4096,
    parameter int DELAY_TICKS      = 50000,
    parameter int RESET_TICKS      = 500000,
    parameter int POST_RESET_TICKS = 300000,
    parameter int MAX_RETRY        = 3,
    parameter int TIMEOUT_TICKS    = 1000
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              start,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [23:0]       tbl_data,
    output logic              i2c_req,
    output logic              i2c_wren,
    output logic [7:0]        i2c_size,
    output logic [6:0]        i2c_addr,
    output logic [7:0]        i2c_saddr,
    output logic [7:0]        i2c_tx,
    input  logic [7:0]        i2c_rx,
    input  logic              i2c_busy,
    output logic              rx_reset_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_index,
    output logic [ADDR_W-1:0] entry_count
);

    // One extra bit so the index can reach TABLE_DEPTH == 2^ADDR_W.
    localparam int IDX_W = ADDR_W + 1;

    localparam logic [6:0] DEV_END   = 7'h00;
    localparam logic [6:0] DEV_DELAY = 7'h7F;

    typedef enum logic [3:0] {
        IDLE,
        RST_LOW,
        RST_WAIT,
        FETCH,
        DECODE,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT,
        CHECK,
        DELAY,
        DONE,
        ERROR
    } state_t;

    state_t state;
    state_t state_n;

    logic [IDX_W-1:0] index;
    logic [31:0]      cnt;
    logic [7:0]       retry;
    logic [6:0]       dev_q;
    logic             vfy_q;
    logic [7:0]       sub_q;
    logic [7:0]       dat_q;
    logic [7:0]       rx_q;
    logic [31:0]      dly_ticks;
    logic             entry_done;
    logic             timed;

    assign tbl_addr  = index[ADDR_W-1:0];
    assign i2c_size  = 8'd1;
    assign i2c_addr  = dev_q;
    assign i2c_saddr = sub_q;
    assign i2c_tx    = dat_q;

    assign dly_ticks = 32'(dat_q) * 32'(DELAY_TICKS);

    // Only states that time something advance the shared counter.
    assign timed = (state == RST_LOW)  ||
                   (state == RST_WAIT) ||
                   (state == WR_REQ)   ||
                   (state == RD_REQ)   ||
                   (state == DELAY);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        entry_done = 1'b0;
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_n = RST_LOW;
                end
            end
            RST_LOW: begin
                if (cnt == 32'(RESET_TICKS - 1)) begin
                    state_n = RST_WAIT;
                end
            end
            RST_WAIT: begin
                if (cnt == 32'(POST_RESET_TICKS - 1)) begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                state_n = DECODE;
            end
            DECODE: begin
                if (index == IDX_W'(TABLE_DEPTH)) begin
                    state_n = DONE;
                end else if (tbl_data[23:17] == DEV_END) begin
                    state_n = DONE;
                end else if (tbl_data[23:17] == DEV_DELAY) begin
                    if (tbl_data[7:0] == 8'd0) begin
                        state_n    = FETCH;
                        entry_done = 1'b1;
                    end else begin
                        state_n = DELAY;
                    end
                end else begin
                    state_n = WR_REQ;
                end
            end
            WR_REQ: begin
                if (i2c_busy) begin
                    state_n = WR_WAIT;
                end else if (cnt == 32'(TIMEOUT_TICKS - 1)) begin
                    state_n = ERROR;
                end
            end
            WR_WAIT: begin
                if (!i2c_busy) begin
                    if (vfy_q) begin
                        state_n = RD_REQ;
                    end else begin
                        state_n    = FETCH;
                        entry_done = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (i2c_busy) begin
                    state_n = RD_WAIT;
                end else if (cnt == 32'(TIMEOUT_TICKS - 1)) begin
                    state_n = ERROR;
                end
            end
            RD_WAIT: begin
                if (!i2c_busy) begin
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (rx_q == dat_q) begin
                    state_n    = FETCH;
                    entry_done = 1'b1;
                end else if (retry < 8'(MAX_RETRY)) begin
                    state_n = WR_REQ;
                end else begin
                    state_n = ERROR;
                end
            end
            DELAY: begin
                if (cnt == dly_ticks - 32'd1) begin
                    state_n    = FETCH;
                    entry_done = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            index       <= '0;
            cnt         <= '0;
            retry       <= '0;
            dev_q       <= '0;
            vfy_q       <= 1'b0;
            sub_q       <= '0;
            dat_q       <= '0;
            rx_q        <= '0;
            i2c_req     <= 1'b0;
            i2c_wren    <= 1'b0;
            rx_reset_n  <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_index   <= '0;
            entry_count <= '0;
        end else begin
            if (state_n != state) begin
                cnt <= '0;
            end else if (timed) begin
                cnt <= cnt + 32'd1;
            end

            // Entry fields are held here so the I2C outputs stay
            // stable for the whole transfer, retries included.
            if (state == DECODE) begin
                dev_q <= tbl_data[23:17];
                vfy_q <= tbl_data[16];
                sub_q <= tbl_data[15:8];
                dat_q <= tbl_data[7:0];
            end

            if (state_n == RST_LOW && state != RST_LOW) begin
                index       <= '0;
                entry_count <= '0;
                retry       <= '0;
                done        <= 1'b0;
                error       <= 1'b0;
                busy        <= 1'b1;
                rx_reset_n  <= 1'b0;
            end

            if (state == RST_LOW && state_n == RST_WAIT) begin
                rx_reset_n <= 1'b1;
            end

            if (state_n == WR_REQ && state != WR_REQ) begin
                i2c_req  <= 1'b1;
                i2c_wren <= 1'b1;
            end

            if (state_n == RD_REQ && state != RD_REQ) begin
                i2c_req  <= 1'b1;
                i2c_wren <= 1'b0;
            end

            // Request drops once busy is seen, or on timeout.
            if ((state == WR_REQ || state == RD_REQ) &&
                state_n != state) begin
                i2c_req <= 1'b0;
            end

            if (state == RD_WAIT && state_n == CHECK) begin
                rx_q <= i2c_rx;
            end

            if (state == CHECK && state_n == WR_REQ) begin
                retry <= retry + 8'd1;
            end

            if (entry_done) begin
                entry_count <= entry_count + ADDR_W'(1);
                index       <= index + IDX_W'(1);
                retry       <= '0;
            end

            if (state_n == DONE && state != DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
            end

            if (state_n == ERROR && state != ERROR) begin
                busy      <= 1'b0;
                error     <= 1'b1;
                err_index <= index[ADDR_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// tb_hdmi_cfg_sequencer: scoreboard bench with ROM and I2C slave models.
// Expected transactions come from a table-level reference walk.
module tb_hdmi_cfg_sequencer;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 16;
    localparam int DLY    = 4;
    localparam int RST_T  = 10;
    localparam int POST_T = 5;
    localparam int RETRY  = 2;
    localparam int TMO    = 20;

    logic              CLOCK_50 = 1'b0;
    logic              RESET_N  = 1'b0;
    logic              start    = 1'b0;
    logic [ADDR_W-1:0] tbl_addr;
    logic [23:0]       tbl_data = '0;
    logic              i2c_req;
    logic              i2c_wren;
    logic [7:0]        i2c_size;
    logic [6:0]        i2c_addr;
    logic [7:0]        i2c_saddr;
    logic [7:0]        i2c_tx;
    logic [7:0]        i2c_rx   = '0;
    logic              i2c_busy = 1'b0;
    logic              rx_reset_n;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] err_index;
    logic [ADDR_W-1:0] entry_count;

    always #10 CLOCK_50 = ~CLOCK_50;

    hdmi_cfg_sequencer #(
        .ADDR_W          (ADDR_W),
        .TABLE_DEPTH     (DEPTH),
        .DELAY_TICKS     (DLY),
        .RESET_TICKS     (RST_T),
        .POST_RESET_TICKS(POST_T),
        .MAX_RETRY       (RETRY),
        .TIMEOUT_TICKS   (TMO)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .start      (start),
        .tbl_addr   (tbl_addr),
        .tbl_data   (tbl_data),
        .i2c_req    (i2c_req),
        .i2c_wren   (i2c_wren),
        .i2c_size   (i2c_size),
        .i2c_addr   (i2c_addr),
        .i2c_saddr  (i2c_saddr),
        .i2c_tx     (i2c_tx),
        .i2c_rx     (i2c_rx),
        .i2c_busy   (i2c_busy),
        .rx_reset_n (rx_reset_n),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_index  (err_index),
        .entry_count(entry_count)
    );

    typedef struct packed {
        logic       wren;
        logic [6:0] addr;
        logic [7:0] saddr;
        logic [7:0] tx;
    } txn_t;

    logic [23:0] rom [0:63];
    logic [7:0]  mem [0:32767];
    txn_t        exp_q[$];
    int          req_cyc[$];
    int          end_cyc[$];

    int checks   = 0;
    int failures = 0;
    int exp_done, exp_err, exp_err_idx, exp_cnt;
    int sl_st = 0, sl_wait = 0, sl_hold = 0, sl_corrupt = 0;
    int no_resp = 0, have_cur = 0, cyc = 0;
    int rst_low_cnt = 0, req_hi_cnt = 0, n_wr = 0, n_rd = 0;
    int poke = 0;
    txn_t cur, got;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic cmp_txn(input string nm, input txn_t a, input txn_t e);
        txn_t am, em;
        am = a;
        em = e;
        if (!e.wren) begin
            am.tx = '0;
            em.tx = '0;
        end
        chk(nm, 32'(am), 32'(em));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // ROM with one clock of read latency.
    initial forever begin
        @(posedge CLOCK_50);
        #1;
        tbl_data = rom[tbl_addr];
    end

    // I2C slave + monitor: pops the scoreboard on every request.
    initial forever begin
        @(posedge CLOCK_50);
        #1;
        cyc++;
        if (!rx_reset_n) rst_low_cnt++;
        if (i2c_req) req_hi_cnt++;
        if (!RESET_N) begin
            sl_st    = 0;
            i2c_busy = 1'b0;
            have_cur = 0;
        end else begin
            case (sl_st)
                0: if (i2c_req && no_resp == 0) begin
                    got = {i2c_wren, i2c_addr, i2c_saddr, i2c_tx};
                    if (got.wren) n_wr++;
                    else n_rd++;
                    req_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        have_cur = 0;
                        $display("FAIL unexpected_txn actual=0x%0h required=none",
                                 got);
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1;
                        cmp_txn("txn_req", got, cur);
                    end
                    sl_wait = $urandom_range(0, 3);
                    sl_st = 1;
                end
                1: if (sl_wait == 0) begin
                    i2c_busy = 1'b1;
                    sl_hold = $urandom_range(1, 4);
                    sl_st = 2;
                end else begin
                    sl_wait--;
                end
                2: if (sl_hold == 0) begin
                    got = {i2c_wren, i2c_addr, i2c_saddr, i2c_tx};
                    if (have_cur != 0) cmp_txn("txn_stable", got, cur);
                    if (got.wren) begin
                        mem[{i2c_addr, i2c_saddr}] = i2c_tx;
                    end else if (sl_corrupt > 0) begin
                        i2c_rx = mem[{i2c_addr, i2c_saddr}] ^ 8'hFF;
                        sl_corrupt--;
                    end else begin
                        i2c_rx = mem[{i2c_addr, i2c_saddr}];
                    end
                    i2c_busy = 1'b0;
                    end_cyc.push_back(cyc);
                    sl_st = 0;
                end else begin
                    sl_hold--;
                end
                default: sl_st = 0;
            endcase
        end
    end

    // Table-level reference: which transfers happen and how the run ends.
    task automatic build_model(input int corrupt);
        int idx, cnt, tries, ok;
        logic [23:0] e;
        exp_q.delete();
        exp_done = 0;
        exp_err = 0;
        exp_err_idx = 0;
        idx = 0;
        cnt = 0;
        forever begin
            if (idx == DEPTH) begin
                exp_done = 1;
                break;
            end
            e = rom[idx];
            if (e[23:17] == 7'h00) begin
                exp_done = 1;
                break;
            end
            if (e[23:17] == 7'h7F) begin
                cnt++;
                idx++;
                continue;
            end
            tries = 0;
            ok = 0;
            forever begin
                exp_q.push_back({1'b1, e[23:17], e[15:8], e[7:0]});
                if (!e[16]) begin
                    ok = 1;
                    break;
                end
                exp_q.push_back({1'b0, e[23:17], e[15:8], e[7:0]});
                if (corrupt == 0) begin
                    ok = 1;
                    break;
                end
                corrupt--;
                if (tries == RETRY) break;
                tries++;
            end
            if (ok == 0) begin
                exp_err = 1;
                exp_err_idx = idx;
                break;
            end
            cnt++;
            idx++;
        end
        exp_cnt = cnt;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) begin
            rom[i] = {7'h3A, 1'b0, 8'(i), 8'hEE};
        end
    endtask

    task automatic clear_counts();
        rst_low_cnt = 0;
        req_hi_cnt = 0;
        n_wr = 0;
        n_rd = 0;
        req_cyc.delete();
        end_cyc.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_end(input string nm, input int budget);
        int n;
        n = 0;
        while (!(done || error) && n < budget) begin
            start = (poke != 0 && (n == 6 || n == 30)) ? 1'b1 : 1'b0;
            tick(1);
            n++;
        end
        start = 1'b0;
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d required=<%0d", nm, n, budget);
        end
    endtask

    task automatic run_test(input string nm, input int corrupt);
        build_model(corrupt);
        sl_corrupt = corrupt;
        clear_counts();
        pulse_start();
        wait_end(nm, 5000);
        tick(2);
        chk({nm, "_done"}, 32'(done), 32'(exp_done));
        chk({nm, "_error"}, 32'(error), 32'(exp_err));
        if (exp_err != 0) chk({nm, "_err_index"}, 32'(err_index), 32'(exp_err_idx));
        chk({nm, "_entry_count"}, 32'(entry_count), 32'(exp_cnt));
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_rst_low"}, 32'(rst_low_cnt), 32'(RST_T));
        chk({nm, "_req_idle"}, 32'(i2c_req), 32'd0);
    endtask

    initial begin
        int k, it;
        clear_rom();
        tick(3);
        chk("rst_req", 32'(i2c_req), 32'd0);
        chk("rst_rx_reset_n", 32'(rx_reset_n), 32'd1);
        chk("rst_size", 32'(i2c_size), 32'd1);
        RESET_N = 1'b1;
        tick(2);
        chk("rst_outs", {i2c_wren, busy, done, error, err_index, entry_count},
            32'd0);
        chk("rst_bus", {i2c_addr, i2c_saddr, i2c_tx, tbl_addr}, 32'd0);

        i2c_busy = 1'b1;
        tick(3);
        i2c_busy = 1'b0;
        chk("idle_busy_ignored", {busy, i2c_req, rx_reset_n}, 32'd1);
        tick(1);

        clear_rom();
        rom[0] = {7'h4C, 1'b0, 8'hFF, 8'h80};
        rom[1] = 24'h0;
        run_test("single", 0);
        chk("single_writes", 32'(n_wr), 32'd1);

        clear_rom();
        rom[0] = {7'h4C, 1'b0, 8'h10, 8'h11};
        rom[1] = {7'h7F, 1'b0, 8'h00, 8'h03};
        rom[2] = {7'h4C, 1'b0, 8'h11, 8'h22};
        rom[3] = 24'h0;
        run_test("delay", 0);
        if (req_cyc.size() >= 2 && end_cyc.size() >= 1) begin
            k = req_cyc[1] - end_cyc[0];
            chk("delay_gap_min", 32'(k >= 12), 32'd1);
            chk("delay_gap_max", 32'(k <= 20), 32'd1);
        end else begin
            chk("delay_txn_cnt", 32'(req_cyc.size()), 32'd2);
        end

        clear_rom();
        rom[0] = {7'h4C, 1'b1, 8'h20, 8'hAA};
        rom[1] = 24'h0;
        run_test("vfy_bad", 1000);
        chk("vfy_bad_writes", 32'(n_wr), 32'd3);
        chk("vfy_bad_reads", 32'(n_rd), 32'd3);

        run_test("vfy_once", 1);
        chk("vfy_once_writes", 32'(n_wr), 32'd2);
        chk("vfy_once_reads", 32'(n_rd), 32'd2);

        clear_rom();
        rom[0] = {7'h4C, 1'b0, 8'h30, 8'h33};
        rom[1] = 24'h0;
        no_resp = 1;
        clear_counts();
        pulse_start();
        wait_end("tmo", 500);
        chk("tmo_error", 32'(error), 32'd1);
        chk("tmo_err_index", 32'(err_index), 32'd0);
        chk("tmo_req_cycles", 32'(req_hi_cnt), 32'(TMO));
        tick(10);
        chk("tmo_req_after", {i2c_req, 31'(req_hi_cnt)}, 32'(TMO));
        no_resp = 0;

        clear_rom();
        rom[0] = {7'h21, 1'b0, 8'h40, 8'h44};
        rom[1] = {7'h22, 1'b1, 8'h41, 8'h45};
        rom[2] = 24'h0;
        build_model(0);
        sl_corrupt = 0;
        pulse_start();
        k = 0;
        while (sl_st != 2 && k < 500) begin
            tick(1);
            k++;
        end
        chk("mid_reached", 32'(sl_st), 32'd2);
        tick(1);
        RESET_N = 1'b0;
        #1;
        chk("mid_req", 32'(i2c_req), 32'd0);
        chk("mid_rx_reset_n", 32'(rx_reset_n), 32'd1);
        chk("mid_status", {busy, done, error, i2c_wren, entry_count}, 32'd0);
        tick(2);
        RESET_N = 1'b1;
        exp_q.delete();
        tick(2);
        poke = 1;
        run_test("rerun", 0);
        poke = 0;
        chk("rerun_writes", 32'(n_wr), 32'd2);
        chk("rerun_reads", 32'(n_rd), 32'd1);

        for (it = 0; it < 8; it++) begin
            clear_rom();
            for (int i = 0; i < DEPTH; i++) begin
                k = $urandom_range(0, 11);
                if (k == 0 && it != 0) rom[i] = 24'h0;
                else if (k <= 2) rom[i] = {7'h7F, 1'b0, 8'h00, 8'($urandom_range(0, 2))};
                else rom[i] = {7'($urandom_range(1, 126)), 1'($urandom_range(0, 1)),
                               8'($urandom), 8'($urandom)};
            end
            run_test($sformatf("rand%0d", it), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog actual=expired required=finish");
        $fatal(1);
    end

endmodule
